// File: rtl/memory_pkg.sv
// Shared definitions for the store-alignment path: write-FSM state encoding,
// strobe width and the layout of one store-buffer entry.
package memory_pkg;

  localparam int STRB_W  = 8;
  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 64;
  localparam int ENTRY_W = ADDR_W + DATA_W + STRB_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// Small circular FIFO holding aligned store entries. SB_DEPTH must be a power
// of two so the pointers wrap naturally. Push is ignored when full, pop when
// empty; simultaneous push and pop keep the count unchanged.
module store_buffer_fifo #(
  parameter int SB_DEPTH = 2,
  parameter int WIDTH    = 136
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [SB_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full      = (count_q == CNT_W'(SB_DEPTH));
  assign empty     = (count_q == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents are only meaningful behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/memory_store_align.sv
// Store alignment unit: lane-shifts store data into a 64-bit doubleword,
// builds byte strobes, buffers stores and issues them one at a time to memory.
// Optional feature macro MISALIGN_TRAP_EN: misaligned stores are trapped
// (reported, dropped) instead of being forced to natural alignment.
//
// state | meaning
// IDLE  | no write in flight, waiting for a buffered store
// SEND  | mem_valid high with head entry, waiting for mem_ready
// WAIT  | write accepted, waiting for mem_bvalid
module memory_store_align
  import memory_pkg::*;
#(
  parameter int SB_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 st_valid,
  output logic                 st_ready,
  input  logic [ADDR_W-1:0]    st_addr,
  input  logic [DATA_W-1:0]    st_data,
  input  logic                 is_byte,
  input  logic                 is_half,
  input  logic                 is_word,
  input  logic                 is_double,
  output logic                 mem_valid,
  input  logic                 mem_ready,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic [STRB_W-1:0]    mem_wstrb,
  input  logic                 mem_bvalid,
  input  logic                 mem_berr,
  output logic                 sb_empty,
  output logic                 bus_err,
  output logic                 misalign_err,
  output logic [ADDR_W-1:0]    misalign_addr
);

  wr_state_e         state_q;
  logic              mem_valid_q;
  logic              bus_err_q;

  logic [2:0]        off;
  logic [2:0]        off_eff;
  logic              any_size;
  logic [DATA_W-1:0] size_mask;
  logic [STRB_W-1:0] strb_base;
  sb_entry_t         push_entry;
  sb_entry_t         head_entry;

  logic              accept;
  logic              trap_hit;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;

  // Lane placement: data masked to its size, offset rounded down to the
  // natural boundary (only matters when misaligned stores are not trapped).
  always_comb begin
    off       = st_addr[2:0];
    any_size  = is_byte || is_half || is_word || is_double;
    off_eff   = off;
    size_mask = 64'h0000_0000_0000_00FF;
    strb_base = 8'h01;
    if (is_double) begin
      off_eff   = 3'b000;
      size_mask = '1;
      strb_base = 8'hFF;
    end else if (is_word) begin
      off_eff   = {off[2], 2'b00};
      size_mask = 64'h0000_0000_FFFF_FFFF;
      strb_base = 8'h0F;
    end else if (is_half) begin
      off_eff   = {off[2:1], 1'b0};
      size_mask = 64'h0000_0000_0000_FFFF;
      strb_base = 8'h03;
    end
    push_entry.addr  = {st_addr[ADDR_W-1:3], 3'b000};
    push_entry.wdata = (st_data & size_mask) << {off_eff, 3'b000};
    push_entry.wstrb = strb_base << off_eff;
  end

  assign st_ready = !fifo_full;
  assign accept   = st_valid && st_ready;
  assign push     = accept && any_size && !trap_hit;
  assign pop      = mem_valid_q && mem_ready;

  store_buffer_fifo #(
    .SB_DEPTH (SB_DEPTH),
    .WIDTH    (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef MISALIGN_TRAP_EN
  logic              misaligned;
  logic              misalign_err_q;
  logic [ADDR_W-1:0] misalign_addr_q;

  assign misaligned = (is_half && off[0]) ||
                      (is_word && (off[1:0] != 2'b00)) ||
                      (is_double && (off != 3'b000));
  assign trap_hit   = accept && any_size && misaligned;

  // Trap report: one-cycle pulse, faulting address held until the next trap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_err_q  <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      misalign_err_q <= trap_hit;
      if (trap_hit) misalign_addr_q <= st_addr;
    end
  end

  assign misalign_err  = misalign_err_q;
  assign misalign_addr = misalign_addr_q;
`else
  assign trap_hit      = 1'b0;
  assign misalign_err  = 1'b0;
  assign misalign_addr = '0;
`endif

  // Write FSM: one outstanding write; responses outside WAIT are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_valid_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_q     <= ST_SEND;
            mem_valid_q <= 1'b1;
          end
        end
        ST_SEND: begin
          if (mem_ready) begin
            state_q     <= ST_WAIT;
            mem_valid_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (mem_bvalid) begin
            state_q   <= ST_IDLE;
            bus_err_q <= mem_berr;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          mem_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Payload comes straight from the FIFO head, which cannot change until pop.
  assign mem_valid = mem_valid_q;
  assign mem_addr  = head_entry.addr;
  assign mem_wdata = head_entry.wdata;
  assign mem_wstrb = head_entry.wstrb;
  assign bus_err   = bus_err_q;
  assign sb_empty  = fifo_empty && (state_q == ST_IDLE);

endmodule

// File: tb/tb_memory_store_align.sv
module tb_memory_store_align;

  localparam logic [3:0] SZ_N = 4'b0000;
  localparam logic [3:0] SZ_B = 4'b0001;
  localparam logic [3:0] SZ_H = 4'b0010;
  localparam logic [3:0] SZ_W = 4'b0100;
  localparam logic [3:0] SZ_D = 4'b1000;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [63:0] st_addr;
  logic [63:0] st_data;
  logic        is_byte, is_half, is_word, is_double;
  logic        mem_valid;
  logic        mem_ready;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_bvalid;
  logic        mem_berr;
  logic        sb_empty;
  logic        bus_err;
  logic        misalign_err;
  logic [63:0] misalign_addr;

  int n_checks = 0;
  int n_errors = 0;

  memory_store_align #(.SB_DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .st_valid      (st_valid),
    .st_ready      (st_ready),
    .st_addr       (st_addr),
    .st_data       (st_data),
    .is_byte       (is_byte),
    .is_half       (is_half),
    .is_word       (is_word),
    .is_double     (is_double),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_bvalid    (mem_bvalid),
    .mem_berr      (mem_berr),
    .sb_empty      (sb_empty),
    .bus_err       (bus_err),
    .misalign_err  (misalign_err),
    .misalign_addr (misalign_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_store(input logic [63:0] a, input logic [63:0] d, input logic [3:0] sz);
    st_addr = a;
    st_data = d;
    {is_double, is_word, is_half, is_byte} = sz;
  endtask

  // Present one store and hold it for exactly the accepting edge.
  task automatic do_store(input string tag, input logic [63:0] a, input logic [63:0] d,
                          input logic [3:0] sz);
    int n;
    n = 0;
    while (!st_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_st_ready"}, st_ready, 1'b1);
    st_valid = 1'b1;
    set_store(a, d, sz);
    tick();
    st_valid = 1'b0;
    set_store(64'h0, 64'h0, SZ_N);
  endtask

  // Wait for a write, check its payload, then complete it with a response.
  task automatic expect_write(input string tag, input logic [63:0] ea, input logic [63:0] ed,
                              input logic [7:0] es, input logic berr);
    int n;
    n = 0;
    while (!mem_valid && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, mem_valid, 1'b1);
    chk({tag, "_addr"}, mem_addr, ea);
    chk({tag, "_wdata"}, mem_wdata, ed);
    chk({tag, "_wstrb"}, {56'h0, mem_wstrb}, {56'h0, es});
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk({tag, "_valid_wait"}, mem_valid, 1'b0);
    mem_bvalid = 1'b1;
    mem_berr   = berr;
    tick();
    mem_bvalid = 1'b0;
    mem_berr   = 1'b0;
    chk({tag, "_bus_err"}, bus_err, berr);
    tick();
    chk({tag, "_bus_err_clr"}, bus_err, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    st_valid   = 1'b0;
    mem_ready  = 1'b0;
    mem_bvalid = 1'b0;
    mem_berr   = 1'b0;
    set_store(64'h0, 64'h0, SZ_N);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_sb_empty", sb_empty, 1'b1);
    chk("rst_st_ready", st_ready, 1'b1);
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_misalign_err", misalign_err, 1'b0);
    chk("rst_misalign_addr", misalign_addr, 64'h0);

    // Byte store at offset 3; sb_empty falls the cycle after accept, mem_valid not yet up
    do_store("sb", 64'h8000_0003, 64'h0000_0000_0000_00AB, SZ_B);
    chk("sb_sb_empty_fall", sb_empty, 1'b0);
    chk("sb_no_early_valid", mem_valid, 1'b0);
    expect_write("sb", 64'h8000_0000, 64'h0000_0000_AB00_0000, 8'h08, 1'b0);
    chk("sb_sb_empty_back", sb_empty, 1'b1);

    // Word, double and a half with upper garbage that must be masked off
    do_store("sw", 64'h8000_0004, 64'h0000_0000_1234_5678, SZ_W);
    expect_write("sw", 64'h8000_0000, 64'h1234_5678_0000_0000, 8'hF0, 1'b0);
    do_store("sd", 64'h8000_0008, 64'h0123_4567_89AB_CDEF, SZ_D);
    expect_write("sd", 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0);
    do_store("sh2", 64'h8000_0012, 64'hFFFF_FFFF_DEAD_BEEF, SZ_H);
    expect_write("sh2", 64'h8000_0010, 64'h0000_0000_BEEF_0000, 8'h0C, 1'b0);

    // No size bit: accepted, nothing queued, nothing sent
    do_store("noop", 64'h8000_0020, 64'h55, SZ_N);
    chk("noop_sb_empty", sb_empty, 1'b1);
    tick();
    tick();
    chk("noop_mem_valid", mem_valid, 1'b0);
    chk("noop_misalign", misalign_err, 1'b0);

    // Three stores back-to-back against a stalled memory
    st_valid = 1'b1;
    set_store(64'h100, 64'h11, SZ_B);
    tick();
    set_store(64'h202, 64'h2222, SZ_H);
    tick();
    chk("bp_st_ready_full", st_ready, 1'b0);
    set_store(64'h304, 64'h3333_3333, SZ_W);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_ready", st_ready, 1'b0);
      chk("bp_hold_valid", mem_valid, 1'b1);
      chk("bp_hold_addr", mem_addr, 64'h100);
      chk("bp_hold_wdata", mem_wdata, 64'h11);
      tick();
    end
    mem_ready = 1'b1;
    chk("bp_full_pop_ready", st_ready, 1'b0);
    tick();
    mem_ready = 1'b0;
    chk("bp_ready_after_pop", st_ready, 1'b1);
    tick();
    st_valid = 1'b0;
    set_store(64'h0, 64'h0, SZ_N);
    mem_bvalid = 1'b1;
    tick();
    mem_bvalid = 1'b0;
    expect_write("bp_b", 64'h200, 64'h0000_0000_2222_0000, 8'h0C, 1'b0);
    expect_write("bp_c", 64'h300, 64'h3333_3333_0000_0000, 8'hF0, 1'b0);
    chk("bp_sb_empty", sb_empty, 1'b1);

    // Misaligned half store
    do_store("mis", 64'h8000_0001, 64'h0000_0000_0000_BEEF, SZ_H);
`ifdef MISALIGN_TRAP_EN
    chk("mis_err_pulse", misalign_err, 1'b1);
    chk("mis_addr", misalign_addr, 64'h8000_0001);
    chk("mis_sb_empty", sb_empty, 1'b1);
    tick();
    chk("mis_err_clr", misalign_err, 1'b0);
    chk("mis_addr_held", misalign_addr, 64'h8000_0001);
    tick();
    chk("mis_no_valid", mem_valid, 1'b0);
`else
    chk("mis_err_tied", misalign_err, 1'b0);
    expect_write("mis", 64'h8000_0000, 64'h0000_0000_0000_BEEF, 8'h03, 1'b0);
    chk("mis_addr_tied", misalign_addr, 64'h0);
`endif

    // Stray response in IDLE is ignored
    mem_bvalid = 1'b1;
    mem_berr   = 1'b1;
    tick();
    mem_bvalid = 1'b0;
    mem_berr   = 1'b0;
    chk("stray_bus_err", bus_err, 1'b0);
    chk("stray_sb_empty", sb_empty, 1'b1);

    // Error response
    do_store("berr", 64'h40, 64'h5A, SZ_B);
    expect_write("berr", 64'h40, 64'h5A, 8'h01, 1'b1);
    chk("berr_sb_empty", sb_empty, 1'b1);

    // Reset while waiting for a response with another entry queued
    do_store("rx", 64'h500, 64'h77, SZ_B);
    do_store("ry", 64'h508, 64'h88, SZ_B);
    chk("rw_valid", mem_valid, 1'b1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("rw_in_wait", mem_valid, 1'b0);
    chk("rw_not_empty", sb_empty, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_sb_empty", sb_empty, 1'b1);
    chk("rw_mem_valid", mem_valid, 1'b0);
    chk("rw_st_ready", st_ready, 1'b1);
    mem_bvalid = 1'b1;
    mem_berr   = 1'b1;
    tick();
    mem_bvalid = 1'b0;
    mem_berr   = 1'b0;
    chk("rw_bus_err", bus_err, 1'b0);
    tick();
    tick();
    chk("rw_valid_later", mem_valid, 1'b0);
    chk("rw_empty_later", sb_empty, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
